// File: rtl/traffic_pkg.sv
// Shared phase codes and lamp patterns for the intersection controller.
package traffic_pkg;

  // Phase register encoding; codes 6 (when flashing is not built) and 7 are illegal.
  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED1  = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED2  = 3'd5,
    FLASH = 3'd6
  } phase_e;

  // Lamp patterns, ordered {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase down-counter: loads a value, counts to zero and holds there; tc flags zero.
module traffic_phase_timer #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller: main road A rests in green, side road B is
// served on a latched request, with all-red clearance between greens.
// Build option NIGHT_FLASH_EN adds a night flashing phase driven by night_mode.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned T_GREEN_A = 20,
  parameter int unsigned T_GREEN_B = 10,
  parameter int unsigned T_YELLOW  = 4,
  parameter int unsigned T_ALL_RED = 2,
  parameter int unsigned T_FLASH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_req,
  input  logic       night_mode,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic [2:0] phase,
  output logic       phase_change,
  output logic       b_pending
);

  // Timer load values: a phase of T cycles loads T-1 so tc lands on its last cycle.
  localparam logic [CNT_W-1:0] LD_GREEN_A = CNT_W'(T_GREEN_A - 1);
  localparam logic [CNT_W-1:0] LD_GREEN_B = CNT_W'(T_GREEN_B - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_FLASH   = CNT_W'(T_FLASH - 1);

  phase_e           phase_q, phase_d;
  logic             b_pending_q, b_pending_d;
  logic             phase_change_q, phase_change_d;
  logic             flash_on_q, flash_on_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_tc;
  logic             night;

`ifdef NIGHT_FLASH_EN
  assign night = night_mode;
`else
  // Without the flashing option the night request is ignored.
  logic unused_night_mode;
  assign night             = 1'b0;
  assign unused_night_mode = night_mode;
`endif

  traffic_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALL_RED)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .tc    (tmr_tc)
  );

  // Next phase, timer reload, request latch and change pulse.
  always_comb begin
    phase_d    = phase_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    flash_on_d = flash_on_q;
    case (phase_q)
      A_GRN: begin
        // A rests in green at tc until there is something to serve.
        if (tmr_tc && (b_pending_q || night)) begin
          phase_d = A_YEL; tmr_load = 1'b1; tmr_value = LD_YELLOW;
        end
      end
      A_YEL: begin
        if (tmr_tc) begin
          phase_d = RED1; tmr_load = 1'b1; tmr_value = LD_ALL_RED;
        end
      end
      RED1: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (night) begin
            phase_d = FLASH; tmr_value = LD_FLASH; flash_on_d = 1'b1;
          end else begin
            phase_d = B_GRN; tmr_value = LD_GREEN_B;
          end
        end
      end
      B_GRN: begin
        if (tmr_tc) begin
          phase_d = B_YEL; tmr_load = 1'b1; tmr_value = LD_YELLOW;
        end
      end
      B_YEL: begin
        if (tmr_tc) begin
          phase_d = RED2; tmr_load = 1'b1; tmr_value = LD_ALL_RED;
        end
      end
      RED2: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (night) begin
            phase_d = FLASH; tmr_value = LD_FLASH; flash_on_d = 1'b1;
          end else begin
            phase_d = A_GRN; tmr_value = LD_GREEN_A;
          end
        end
      end
`ifdef NIGHT_FLASH_EN
      FLASH: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (night) begin
            tmr_value = LD_FLASH; flash_on_d = ~flash_on_q;
          end else begin
            phase_d = RED2; tmr_value = LD_ALL_RED;
          end
        end
      end
`endif
      default: begin
        // Corrupted phase code: recover through all-red.
        phase_d = RED2; tmr_load = 1'b1; tmr_value = LD_ALL_RED;
      end
    endcase

    // Clearing on B_GRN entry beats a same-cycle request.
    b_pending_d = (b_pending_q || (b_req && (phase_q != B_GRN)))
                  && !((phase_q == RED1) && (phase_d == B_GRN));
    phase_change_d = (phase_d != phase_q);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= RED2;
      b_pending_q    <= 1'b0;
      phase_change_q <= 1'b0;
      flash_on_q     <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      b_pending_q    <= b_pending_d;
      phase_change_q <= phase_change_d;
      flash_on_q     <= flash_on_d;
    end
  end

  // Lamp decode straight from the phase register; anything unknown shows red.
  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    case (phase_q)
      A_GRN:   light_a = LAMP_GRN;
      A_YEL:   light_a = LAMP_YEL;
      B_GRN:   light_b = LAMP_GRN;
      B_YEL:   light_b = LAMP_YEL;
      FLASH: begin
        light_a = flash_on_q ? LAMP_YEL : LAMP_OFF;
        light_b = flash_on_q ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign phase        = phase_q;
  assign phase_change = phase_change_q;
  assign b_pending    = b_pending_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl with short phase durations.
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] light_a, light_b, phase;
  logic       phase_change, b_pending;

  localparam logic [2:0] P_AG = 3'd0, P_AY = 3'd1, P_R1 = 3'd2, P_BG = 3'd3,
                         P_BY = 3'd4, P_R2 = 3'd5, P_FL = 3'd6;

  traffic_intersection_ctrl #(
    .CNT_W     (8),
    .T_GREEN_A (5),
    .T_GREEN_B (3),
    .T_YELLOW  (2),
    .T_ALL_RED (1),
    .T_FLASH   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .b_req        (b_req),
    .night_mode   (night_mode),
    .light_a      (light_a),
    .light_b      (light_b),
    .phase        (phase),
    .phase_change (phase_change),
    .b_pending    (b_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] la;
    logic [2:0] lb;
    logic       pc;
    logic       bp;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       breq;
    logic       night;
    logic [2:0] ph;
    logic       pc;
    logic       bp;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [2:0] lamp_a_of(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp_b_of(input logic [2:0] ph);
    case (ph)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Drive one cycle of inputs, queue the expectation, then compare after the edge.
  task automatic step(input logic rst, input logic breq, input logic night,
                      input logic [2:0] ph, input logic [2:0] la, input logic [2:0] lb,
                      input logic pc, input logic bp, input string name);
    exp_t e, got;
    reset      = rst;
    b_req      = breq;
    night_mode = night;
    exp_q.push_back('{ph: ph, la: la, lb: lb, pc: pc, bp: bp});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {phase, light_a, light_b, phase_change, b_pending};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got ph=%0d a=%b b=%b pc=%b bp=%b, need ph=%0d a=%b b=%b pc=%b bp=%b",
               name, got.ph, got.la, got.lb, got.pc, got.bp, e.ph, e.la, e.lb, e.pc, e.bp);
    end
    if (phase != P_FL && light_a != 3'b100 && light_b != 3'b100) begin
      miscompares++;
      $display("FAIL safety %s: a=%b b=%b both non-red in phase %0d",
               name, light_a, light_b, phase);
    end
  endtask

  task automatic stepn(input logic rst, input logic breq, input logic night,
                       input logic [2:0] ph, input logic pc, input logic bp,
                       input string name);
    step(rst, breq, night, ph, lamp_a_of(ph), lamp_b_of(ph), pc, bp, name);
  endtask

  task automatic v(input logic rst, input logic breq, input logic [2:0] ph,
                   input logic pc, input logic bp);
    tbl.push_back('{rst: rst, breq: breq, night: 1'b0, ph: ph, pc: pc, bp: bp});
  endtask

  initial begin
    logic [2:0] p4_ph[14] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4,
                              3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       p4_pc[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       p4_bp[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int         pulses;

    // Reset held 3 cycles, release, one full B service, then reset during B_GRN.
    v(1, 0, P_R2, 0, 0); v(1, 0, P_R2, 0, 0); v(1, 0, P_R2, 0, 0);
    v(0, 0, P_AG, 1, 0);
    v(0, 1, P_AG, 0, 1); v(0, 0, P_AG, 0, 1); v(0, 0, P_AG, 0, 1); v(0, 0, P_AG, 0, 1);
    v(0, 0, P_AY, 1, 1); v(0, 0, P_AY, 0, 1);
    v(0, 0, P_R1, 1, 1);
    v(0, 1, P_BG, 1, 0); v(0, 0, P_BG, 0, 0); v(0, 0, P_BG, 0, 0);
    v(0, 0, P_BY, 1, 0); v(0, 0, P_BY, 0, 0);
    v(0, 0, P_R2, 1, 0);
    v(0, 0, P_AG, 1, 0);
    for (int i = 0; i < 5; i++) v(0, 0, P_AG, 0, 0);
    v(0, 1, P_AG, 0, 1);
    v(0, 0, P_AY, 1, 1); v(0, 0, P_AY, 0, 1);
    v(0, 0, P_R1, 1, 1);
    v(0, 0, P_BG, 1, 0);
    v(0, 1, P_BG, 0, 0);
    v(1, 1, P_R2, 0, 0);
    v(0, 0, P_AG, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      stepn(tbl[i].rst, tbl[i].breq, tbl[i].night, tbl[i].ph, tbl[i].pc, tbl[i].bp,
            $sformatf("tbl[%0d]", i));
    end

    // No requests: A stays green.
    for (int i = 0; i < 100; i++) stepn(0, 0, 0, P_AG, 0, 0, $sformatf("idle[%0d]", i));

    // Night request raised during B_GRN.
    stepn(0, 1, 0, P_AG, 0, 1, "night c1");
    stepn(0, 0, 0, P_AY, 1, 1, "night c2");
    stepn(0, 0, 0, P_AY, 0, 1, "night c3");
    stepn(0, 0, 0, P_R1, 1, 1, "night c4");
    stepn(0, 0, 0, P_BG, 1, 0, "night c5");
    stepn(0, 0, 1, P_BG, 0, 0, "night c6");
    stepn(0, 0, 1, P_BG, 0, 0, "night c7");
    stepn(0, 0, 1, P_BY, 1, 0, "night c8");
    stepn(0, 0, 1, P_BY, 0, 0, "night c9");
    stepn(0, 0, 1, P_R2, 1, 0, "night c10");
`ifdef NIGHT_FLASH_EN
    step(0, 0, 1, P_FL, 3'b010, 3'b100, 1, 0, "flash c11");
    step(0, 0, 1, P_FL, 3'b010, 3'b100, 0, 0, "flash c12");
    step(0, 0, 1, P_FL, 3'b000, 3'b000, 0, 0, "flash c13");
    step(0, 0, 1, P_FL, 3'b000, 3'b000, 0, 0, "flash c14");
    step(0, 0, 1, P_FL, 3'b010, 3'b100, 0, 0, "flash c15");
    step(0, 0, 1, P_FL, 3'b010, 3'b100, 0, 0, "flash c16");
    stepn(0, 0, 0, P_R2, 1, 0, "flash exit c17");
    stepn(0, 0, 0, P_AG, 1, 0, "flash exit c18");
`else
    stepn(0, 0, 1, P_AG, 1, 0, "night ignored c11");
    for (int i = 12; i <= 16; i++) stepn(0, 0, 1, P_AG, 0, 0, $sformatf("night ignored c%0d", i));
    stepn(0, 0, 0, P_AG, 0, 0, "night ignored c17");
    stepn(0, 0, 0, P_AG, 0, 0, "night ignored c18");
`endif
    for (int i = 0; i < 5; i++) stepn(0, 0, 0, P_AG, 0, 0, $sformatf("settle[%0d]", i));

    // b_req held: 14-cycle repeating cycle with 6 phase changes each.
    stepn(0, 1, 0, P_AG, 0, 1, "held c0");
    for (int r = 0; r < 3; r++) begin
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
        stepn(0, 1, 0, p4_ph[i], p4_pc[i], p4_bp[i], $sformatf("held r%0d c%0d", r, i));
        if (phase_change) pulses++;
      end
      vectors++;
      if (pulses != 6) begin
        miscompares++;
        $display("FAIL pulses r%0d: got %0d phase changes, need 6", r, pulses);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
